// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell with a registered carry loop, LSB first,
// one bit per clock, with registered sum/carry-out/signed-overflow and a done pulse.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] ss_r;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    count_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;
    logic             cout_r;
    logic             ovf_r;

    logic             fa_sum_s;
    logic             fa_co_s;
    logic [WIDTH-1:0] next_ss_s;
    logic             last_bit_s;

    full_adder u_fa (
        .a  (sa_r[0]),
        .b  (sb_r[0]),
        .ci (carry_r),
        .s  (fa_sum_s),
        .co (fa_co_s)
    );

    // Next partial sum: new bit enters at the MSB, earlier bits move toward the LSB.
    always_comb begin
        next_ss_s            = ss_r >> 1;
        next_ss_s[WIDTH-1]   = fa_sum_s;
        last_bit_s           = (count_r == LAST_BIT);
    end

    // Control FSM and datapath; on the MSB cycle carry_r is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            sa_r    <= '0;
            sb_r    <= '0;
            ss_r    <= '0;
            sum_r   <= '0;
            count_r <= '0;
            carry_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        sa_r    <= a;
                        sb_r    <= b;
                        carry_r <= cin;
                        ss_r    <= '0;
                        count_r <= '0;
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    ss_r    <= next_ss_s;
                    sa_r    <= sa_r >> 1;
                    sb_r    <= sb_r >> 1;
                    carry_r <= fa_co_s;
                    if (last_bit_s) begin
                        sum_r   <= next_ss_s;
                        cout_r  <= fa_co_s;
                        ovf_r   <= carry_r ^ fa_co_s;
                        count_r <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        count_r <= count_r + CW'(1);
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule
